// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and constants for the single-cycle datapath execution controller.
// Holds the FSM state encoding and the retired-instruction counter format.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } ctrl_state_t;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_SAT = 16'hFFFF;

  // Saturating increment for the retired-instruction counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board-side and datapath-side signals of the execution controller.
// The slave modport is the controller; the master modport is its environment.
interface cpu_step_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic               step_key;
  logic               run_sw;
  logic [31:0]        pc;
  logic               step_en;
  logic [1:0]         state;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output step_key, run_sw, pc,
    input  step_en, state, halted, instr_count
  );

  modport slave (
    input  step_key, run_sw, pc,
    output step_en, state, halted, instr_count
  );

endinterface

// File: rtl/cpu_step_ctrl_key_debounce.sv
// Synchronizes and debounces an active-low pushbutton and emits a one-cycle
// press pulse on each accepted 1->0 change of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          stable_d_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  // Synchronizer, stability counter and registered falling-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      stable_r   <= 1'b1;
      stable_d_r <= 1'b1;
      cnt_r      <= '0;
      press_r    <= 1'b0;
    end else begin
      sync1_r    <= key_raw;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      press_r    <= stable_d_r & ~stable_r;
      if (sync2_r != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= sync2_r;
          cnt_r    <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: turns a debounced step key or the run switch into
// single-cycle datapath update enables, halting after the last instruction.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          RUN_DIV         = 50000000,
  parameter logic [31:0] PC_LAST         = 32'd36
) (
  input  logic           clk,
  input  logic           reset,
  cpu_step_ctrl_if.slave bus
);

  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  ctrl_state_t        state_r;
  logic [DW-1:0]      div_r;
  logic [COUNT_W-1:0] count_r;
  logic               run_s1_r;
  logic               run_s;
  logic               press;
  logic               at_term;
  logic               pc_last;
  logic               step_en;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (clk),
    .reset  (reset),
    .key_raw(bus.step_key),
    .press  (press)
  );

  assign at_term = (div_r == DIV_LAST);
  assign pc_last = (bus.pc == PC_LAST);

  // Reset suppresses the enable so a same-cycle reset never advances the datapath.
  assign step_en = ~reset & ((state_r == ST_STEP) |
                             ((state_r == ST_RUN) & at_term & run_s));

  // Switch synchronizer, retired counter, run divider and controller FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      div_r    <= '0;
      count_r  <= '0;
      run_s1_r <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      run_s1_r <= bus.run_sw;
      run_s    <= run_s1_r;
      if (step_en) begin
        count_r <= sat_inc(count_r);
      end
      case (state_r)
        ST_IDLE: begin
          div_r <= '0;
          if (run_s) begin
            state_r <= ST_RUN;
          end else if (press) begin
            state_r <= ST_STEP;
          end
        end
        ST_STEP: begin
          state_r <= pc_last ? ST_HALT : ST_IDLE;
        end
        ST_RUN: begin
          if (!run_s) begin
            state_r <= ST_IDLE;
            div_r   <= '0;
          end else if (at_term) begin
            div_r <= '0;
            if (pc_last) begin
              state_r <= ST_HALT;
            end
          end else begin
            div_r <= div_r + DW'(1);
          end
        end
        ST_HALT: begin
          div_r <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
          div_r   <= '0;
        end
      endcase
    end
  end

  assign bus.step_en     = step_en;
  assign bus.state       = state_r;
  assign bus.halted      = (state_r == ST_HALT);
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3, PC_LAST=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_step_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3),
    .PC_LAST        (32'd8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.step_key = 1'b1;
    bus.run_sw   = 1'b0;
    bus.pc       = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", bus.state);
    end
    vectors++;
    if (bus.step_en !== 1'b0) begin
      errors++; $display("FAIL reset_step_en: got %b expected 0", bus.step_en);
    end
    vectors++;
    if (bus.halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted: got %b expected 0", bus.halted);
    end
    vectors++;
    if (bus.instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0h expected 0", bus.instr_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    bus.step_key = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) bus.step_key = 1'b1;
      vectors++;
      if (bus.step_en !== 1'b0) begin
        errors++; $display("FAIL glitch_step_en[%0d]: got %b expected 0", i, bus.step_en);
      end
    end
    vectors++;
    if (bus.instr_count !== 16'd0) begin
      errors++; $display("FAIL glitch_count: got %0h expected 0", bus.instr_count);
    end
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL glitch_state: got %0d expected 0", bus.state);
    end
  endtask

  task automatic test_step();
    bus.pc       = 32'd0;
    bus.step_key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.step_en !== (i == 7)) begin
        errors++; $display("FAIL step_en[%0d]: got %b expected %b", i, bus.step_en, (i == 7));
      end
      if (i == 7) begin
        vectors++;
        if (bus.state !== 2'd1) begin
          errors++; $display("FAIL step_state_step: got %0d expected 1", bus.state);
        end
      end
      if (i == 9) bus.step_key = 1'b1;
    end
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL step_state_idle: got %0d expected 0", bus.state);
    end
    vectors++;
    if (bus.instr_count !== 16'd1) begin
      errors++; $display("FAIL step_count: got %0h expected 1", bus.instr_count);
    end
  endtask

  task automatic test_run();
    bus.pc     = 32'd0;
    bus.run_sw = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.step_en !== (i == 4 || i == 7 || i == 10)) begin
        errors++; $display("FAIL run_step_en[%0d]: got %b expected %b", i, bus.step_en,
                           (i == 4 || i == 7 || i == 10));
      end
      if (i == 1 || i == 2) begin
        vectors++;
        if (bus.state !== ((i == 2) ? 2'd2 : 2'd0)) begin
          errors++; $display("FAIL run_entry_state[%0d]: got %0d expected %0d", i, bus.state,
                             (i == 2) ? 2 : 0);
        end
      end
      if (i == 5) bus.pc = 32'd4;
      if (i == 8) bus.pc = 32'd8;
    end
    vectors++;
    if (bus.halted !== 1'b1) begin
      errors++; $display("FAIL run_halted: got %b expected 1", bus.halted);
    end
    vectors++;
    if (bus.state !== 2'd3) begin
      errors++; $display("FAIL run_state_halt: got %0d expected 3", bus.state);
    end
    vectors++;
    if (bus.instr_count !== 16'd3) begin
      errors++; $display("FAIL run_count: got %0h expected 3", bus.instr_count);
    end
  endtask

  task automatic test_halt_reset();
    bus.step_key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.step_en !== 1'b0 || bus.state !== 2'd3 || bus.halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold[%0d]: got en=%b st=%0d h=%b expected en=0 st=3 h=1",
                           i, bus.step_en, bus.state, bus.halted);
      end
      if (i == 5)  bus.run_sw   = 1'b0;
      if (i == 8)  bus.run_sw   = 1'b1;
      if (i == 10) bus.step_key = 1'b1;
    end
    bus.run_sw = 1'b0;
    bus.pc     = 32'd0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL halt_reset_state: got %0d expected 0", bus.state);
    end
    vectors++;
    if (bus.halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset_halted: got %b expected 0", bus.halted);
    end
    vectors++;
    if (bus.instr_count !== 16'd0) begin
      errors++; $display("FAIL halt_reset_count: got %0h expected 0", bus.instr_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_run_abort();
    bus.pc     = 32'd0;
    bus.run_sw = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.step_en !== (i == 4)) begin
        errors++; $display("FAIL abort_step_en[%0d]: got %b expected %b", i, bus.step_en, (i == 4));
      end
      if (i == 7 || i == 8) begin
        vectors++;
        if (bus.state !== ((i == 7) ? 2'd2 : 2'd0)) begin
          errors++; $display("FAIL abort_state[%0d]: got %0d expected %0d", i, bus.state,
                             (i == 7) ? 2 : 0);
        end
      end
      if (i == 5) bus.run_sw = 1'b0;
    end
    bus.run_sw = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      vectors++;
      if (bus.step_en !== (j == 4)) begin
        errors++; $display("FAIL reentry_step_en[%0d]: got %b expected %b", j, bus.step_en, (j == 4));
      end
      if (j == 4) bus.run_sw = 1'b0;
    end
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++; $display("FAIL reentry_idle: got %0d expected 0", bus.state);
    end
    vectors++;
    if (bus.instr_count !== 16'd2) begin
      errors++; $display("FAIL abort_count: got %0h expected 2", bus.instr_count);
    end
  endtask

  task automatic test_reset_on_pulse();
    bus.pc     = 32'd0;
    bus.run_sw = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.step_en !== 1'b1) begin
      errors++; $display("FAIL rop_pulse_present: got %b expected 1", bus.step_en);
    end
    reset      = 1'b1;
    bus.run_sw = 1'b0;
    #1;
    vectors++;
    if (bus.step_en !== 1'b0) begin
      errors++; $display("FAIL rop_pulse_suppressed: got %b expected 0", bus.step_en);
    end
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.state !== 2'd0 || bus.instr_count !== 16'd0) begin
      errors++; $display("FAIL rop_after: got st=%0d cnt=%0h expected st=0 cnt=0",
                         bus.state, bus.instr_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    force dut.count_r = 16'hFFFD;
    @(negedge clk);
    release dut.count_r;
    bus.pc     = 32'd4;
    bus.run_sw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 5 || i == 8 || i == 11 || i == 14) begin
        vectors++;
        if (bus.instr_count !== ((i == 5) ? 16'hFFFE : 16'hFFFF)) begin
          errors++; $display("FAIL sat_count[%0d]: got %0h expected %0h", i, bus.instr_count,
                             (i == 5) ? 16'hFFFE : 16'hFFFF);
        end
      end
    end
    vectors++;
    if (bus.state !== 2'd2) begin
      errors++; $display("FAIL sat_state: got %0d expected 2", bus.state);
    end
    bus.run_sw = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_glitch();
    test_step();
    do_reset();
    test_run();
    test_halt_reset();
    test_run_abort();
    test_reset_on_pulse();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
